if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL give the bubble instruction driven when no valid instruction is held.
REQ-003 clock  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 StallF  input  1  SHALL, when high, hold the currently presented instruction and PC.
REQ-006 PCSrcE  input  1  SHALL, when high, request a redirect (taken branch or jump).
REQ-007 PCTargetE  input  32  SHALL be the redirect target address.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request strobe.
REQ-009 imem_addr  output  32  SHALL be the request address, driven from the PC register.
REQ-010 imem_ready  input  1  SHALL be high when memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  SHALL be high when imem_rdata is valid.
REQ-012 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-013 InstrF, PCF, PCPlus4F  output  32 each  SHALL be the fetched instruction, its address and that address + 4, for the IF/ID register.
REQ-014 ValidF  output  1  SHALL be high while InstrF holds a real fetched instruction.

Function
REQ-015 The block SHALL use a three-state FSM: S_REQ, S_WAIT, S_HOLD.
REQ-016 Only one memory request SHALL be outstanding at a time.
REQ-017 S_REQ SHALL drive imem_req=1 and imem_addr=PC; on imem_ready it SHALL move to S_WAIT.
REQ-018 S_WAIT SHALL drive imem_req=0; on imem_rvalid with drop=0 it SHALL capture imem_rdata into InstrF, PC into PCF, PC+4 into PCPlus4F, set ValidF=1 and move to S_HOLD.
REQ-019 S_WAIT on imem_rvalid with drop=1 SHALL discard the data, clear drop and move to S_REQ.
REQ-020 S_HOLD with StallF=0 SHALL set PC=PC+4 and ValidF=0, load NOP_INSTR into InstrF and move to S_REQ.
REQ-021 S_HOLD with StallF=1 SHALL hold all outputs and PC unchanged.
REQ-022 PCSrcE=1 SHALL have priority over StallF and FSM progress in every state.
REQ-023 On PCSrcE=1 the block SHALL set PC=PCTargetE, ValidF=0 and InstrF=NOP_INSTR.
REQ-024 On PCSrcE=1 the next state SHALL be S_REQ, with one exception.
REQ-025 The exception (REQ-024) SHALL apply in S_WAIT without imem_rvalid, or in S_REQ with imem_ready: the next state SHALL be S_WAIT with drop=1, so the stale response is discarded.
REQ-026 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-027 Minimum latency SHALL be 2 cycles from request to ValidF (ready in cycle 0, rvalid in cycle 1, ValidF in cycle 2).
REQ-028 imem_rvalid in S_REQ or S_HOLD SHALL be ignored.

Reset
REQ-029 Reset SHALL force PC=RESET_PC, state=S_REQ, drop=0, ValidF=0, InstrF=NOP_INSTR, PCF=0, PCPlus4F=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; a later imem_rvalid SHALL be ignored.
REQ-031 imem_req SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 With macro IF_FETCH_PERF_EN defined, the block SHALL add output fetch_count (32) and output redirect_count (32), both reset to 0.
REQ-033 fetch_count SHALL increment, wrapping, on each consumed instruction (ValidF=1, StallF=0, PCSrcE=0).
REQ-034 redirect_count SHALL increment on each cycle with PCSrcE=1.
REQ-035 Without IF_FETCH_PERF_EN, neither counter port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-036 Zero-wait memory, no stalls, RESET_PC=0 -> ValidF pulses with PCF=0,4,8 and PCPlus4F=4,8,12; InstrF equals memory contents.
REQ-037 StallF=1 held 5 cycles in S_HOLD at PCF=8 -> InstrF, PCF and ValidF stable; no imem_req until StallF=0.
REQ-038 PCSrcE=1 with PCTargetE=32'h100 while in S_WAIT, rvalid 3 cycles later -> response dropped, ValidF=0, next imem_addr=32'h100.
REQ-039 PCSrcE=1 and StallF=1 in the same S_HOLD cycle -> redirect wins: ValidF=0, InstrF=32'h0000_0013, next imem_addr=PCTargetE.
REQ-040 PC=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000.
REQ-041 With IF_FETCH_PERF_EN: 3 instructions consumed and 1 redirect -> fetch_count=3, redirect_count=1; after reset both 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect with stale-response drop.
// Optional perf counters (fetch_count, redirect_count) enabled by macro IF_FETCH_PERF_EN.
module if_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        ValidF
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] redirect_count
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } fetch_t;

   state_t      state;
   logic [31:0] pc;
   logic        drop;
   fetch_t      fet;

   assign imem_addr = pc;
   assign InstrF    = fet.instr;
   assign PCF       = fet.pc;
   assign PCPlus4F  = fet.pc_plus4;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         drop     <= 1'b0;
         imem_req <= 1'b1;
         ValidF   <= 1'b0;
         fet      <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
      end else if (PCSrcE) begin
         pc        <= PCTargetE;
         ValidF    <= 1'b0;
         fet.instr <= NOP_INSTR;
         // A request memory has accepted but not answered must still be drained.
         if ((state == S_WAIT && !imem_rvalid) || (state == S_REQ && imem_ready)) begin
            state    <= S_WAIT;
            drop     <= 1'b1;
            imem_req <= 1'b0;
         end else begin
            state    <= S_REQ;
            drop     <= 1'b0;
            imem_req <= 1'b1;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  state    <= S_WAIT;
                  imem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop) begin
                     drop     <= 1'b0;
                     state    <= S_REQ;
                     imem_req <= 1'b1;
                  end else begin
                     fet    <= '{instr: imem_rdata, pc: pc, pc_plus4: pc + 32'd4};
                     ValidF <= 1'b1;
                     state  <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!StallF) begin
                  pc        <= pc + 32'd4;
                  ValidF    <= 1'b0;
                  fet.instr <= NOP_INSTR;
                  state     <= S_REQ;
                  imem_req  <= 1'b1;
               end
            end
            default: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
         endcase
      end
   end

`ifdef IF_FETCH_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_count    <= 32'h0;
         redirect_count <= 32'h0;
      end else begin
         if (ValidF && !StallF && !PCSrcE) fetch_count <= fetch_count + 32'd1;
         if (PCSrcE) redirect_count <= redirect_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory responder, per-cycle model compare, literal spot checks.
module tb_if_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        StallF = 1'b0, PCSrcE = 1'b0;
   logic [31:0] PCTargetE = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] InstrF, PCF, PCPlus4F;
   logic        ValidF;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_count, redirect_count;
`endif

   if_fetch dut (
      .clock(clock), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
`ifdef IF_FETCH_PERF_EN
      , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return 32'hC0DE_0000 + a;
   endfunction

   // Memory responder state
   logic        ready_en = 1'b0, force_rv = 1'b0, pend = 1'b0;
   int          lat = 0, cnt = 0;
   logic [31:0] paddr = 32'h0;

   task automatic respond();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (force_rv) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end else if (pend) begin
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(paddr);
            pend = 1'b0;
         end else cnt--;
      end
      imem_ready = ready_en && imem_req;
      if (imem_ready) begin
         pend  = 1'b1;
         cnt   = lat;
         paddr = imem_addr;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      respond();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!ValidF && n < 30);
      if (!ValidF) begin
         checks++;
         failures++;
         $display("FAIL %s timeout waiting for ValidF", name);
      end
   endtask

   // Abstract model: outstanding / holding / drop flags instead of named states.
   logic [31:0] m_pc, m_instr, m_pcf, m_pc4, m_fc, m_rc;
   logic        m_out, m_have, m_drop;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_pc <= 32'h0; m_instr <= NOP; m_pcf <= 32'h0; m_pc4 <= 32'h0;
         m_out <= 1'b0; m_have <= 1'b0; m_drop <= 1'b0; m_fc <= 32'h0; m_rc <= 32'h0;
      end else begin
         if (PCSrcE) m_rc <= m_rc + 1;
         if (m_have && !StallF && !PCSrcE) m_fc <= m_fc + 1;
         if (PCSrcE) begin
            m_pc    <= PCTargetE;
            m_have  <= 1'b0;
            m_instr <= NOP;
            m_out   <= (m_out && !imem_rvalid) || (!m_out && !m_have && imem_ready);
            m_drop  <= (m_out && !imem_rvalid) || (!m_out && !m_have && imem_ready);
         end else if (!m_out && !m_have) begin
            if (imem_ready) m_out <= 1'b1;
         end else if (m_out) begin
            if (imem_rvalid) begin
               m_out <= 1'b0;
               if (m_drop) m_drop <= 1'b0;
               else begin
                  m_have <= 1'b1; m_instr <= imem_rdata; m_pcf <= m_pc; m_pc4 <= m_pc + 4;
               end
            end
         end else if (!StallF) begin
            m_pc <= m_pc + 4; m_have <= 1'b0; m_instr <= NOP;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cmp_req", {31'h0, imem_req}, {31'h0, !m_out && !m_have});
         chk("cmp_addr", imem_addr, m_pc);
         chk("cmp_valid", {31'h0, ValidF}, {31'h0, m_have});
         chk("cmp_instr", InstrF, m_instr);
         chk("cmp_pcf", PCF, m_pcf);
         chk("cmp_pc4", PCPlus4F, m_pc4);
`ifdef IF_FETCH_PERF_EN
         chk("cmp_fcnt", fetch_count, m_fc);
         chk("cmp_rcnt", redirect_count, m_rc);
`endif
      end
   end

   initial begin
      tick(); tick();
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_valid", {31'h0, ValidF}, 32'h0);
      chk("rst_instr", InstrF, 32'h0000_0013);
      chk("rst_pcf", PCF, 32'h0);
      chk("rst_pc4", PCPlus4F, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h1);
      chk("rst_addr", imem_addr, 32'h0);

      // Zero-wait sequential fetch
      ready_en = 1'b1; lat = 0;
      wait_valid("seq0");
      chk("seq0_pcf", PCF, 32'h0); chk("seq0_pc4", PCPlus4F, 32'h4); chk("seq0_instr", InstrF, 32'hC0DE_0000);
      wait_valid("seq1");
      chk("seq1_pcf", PCF, 32'h4); chk("seq1_pc4", PCPlus4F, 32'h8); chk("seq1_instr", InstrF, 32'hC0DE_0004);
      tick();
      StallF = 1'b1;
      wait_valid("seq2");
      chk("seq2_pcf", PCF, 32'h8); chk("seq2_pc4", PCPlus4F, 32'hC); chk("seq2_instr", InstrF, 32'hC0DE_0008);

      // Stall in hold for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", {31'h0, ValidF}, 32'h1);
         chk("stall_pcf", PCF, 32'h8);
         chk("stall_instr", InstrF, 32'hC0DE_0008);
         chk("stall_req", {31'h0, imem_req}, 32'h0);
      end

      // Redirect while waiting, stale response 3 cycles later
      StallF = 1'b0; lat = 3;
      begin
         int n = 0;
         do begin tick(); n++; end while (!imem_ready && n < 10);
         if (!imem_ready) begin checks++; failures++; $display("FAIL wait_accept timeout"); end
      end
      lat = 0;
      tick();
      PCSrcE = 1'b1; PCTargetE = 32'h100;
      tick();
      PCSrcE = 1'b0;
      chk("rdw_req", {31'h0, imem_req}, 32'h0); chk("rdw_valid", {31'h0, ValidF}, 32'h0);
      tick(); tick();
      chk("rdw_req2", {31'h0, imem_req}, 32'h0);
      tick();
      chk("rdw_req3", {31'h0, imem_req}, 32'h1); chk("rdw_addr", imem_addr, 32'h100);
      chk("rdw_valid2", {31'h0, ValidF}, 32'h0);
      wait_valid("rdw_fetch");
      chk("rdw_pcf", PCF, 32'h100); chk("rdw_pc4", PCPlus4F, 32'h104); chk("rdw_instr", InstrF, 32'hC0DE_0100);

      // Redirect beats stall in hold
      StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
      tick();
      PCSrcE = 1'b0; StallF = 1'b0;
      chk("rds_valid", {31'h0, ValidF}, 32'h0); chk("rds_instr", InstrF, 32'h0000_0013);
      chk("rds_addr", imem_addr, 32'h200); chk("rds_req", {31'h0, imem_req}, 32'h1);
      wait_valid("rds_fetch");
      chk("rds_pcf", PCF, 32'h200);

      // PC wrap
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      tick();
      PCSrcE = 1'b0;
      wait_valid("wrap_fetch");
      chk("wrap_pcf", PCF, 32'hFFFF_FFFC); chk("wrap_pc4", PCPlus4F, 32'h0);
      chk("wrap_instr", InstrF, 32'hC0DD_FFFC);
      tick();
      chk("wrap_addr", imem_addr, 32'h0); chk("wrap_req", {31'h0, imem_req}, 32'h1);

      // Redirect in the same cycle memory accepts the request
      PCSrcE = 1'b1; PCTargetE = 32'h300;
      tick();
      PCSrcE = 1'b0;
      chk("rdr_req", {31'h0, imem_req}, 32'h0); chk("rdr_valid", {31'h0, ValidF}, 32'h0);
      tick();
      chk("rdr_req2", {31'h0, imem_req}, 32'h1); chk("rdr_addr", imem_addr, 32'h300);
      wait_valid("rdr_fetch");
      chk("rdr_pcf", PCF, 32'h300); chk("rdr_instr", InstrF, 32'hC0DE_0300);

      // Stray rvalid in hold and in request phase is ignored
      StallF = 1'b1; force_rv = 1'b1; ready_en = 1'b0;
      tick();
      force_rv = 1'b0;
      tick();
      chk("stray_hold_valid", {31'h0, ValidF}, 32'h1); chk("stray_hold_instr", InstrF, 32'hC0DE_0300);
      StallF = 1'b0;
      tick();
      force_rv = 1'b1;
      tick();
      force_rv = 1'b0;
      tick();
      chk("stray_req_valid", {31'h0, ValidF}, 32'h0); chk("stray_req_req", {31'h0, imem_req}, 32'h1);
      chk("stray_req_addr", imem_addr, 32'h304);
      ready_en = 1'b1;
      wait_valid("stray_fetch");
      chk("stray_pcf", PCF, 32'h304); chk("stray_instr", InstrF, 32'hC0DE_0304);

      // Reset mid-request; late response ignored
      lat = 2;
      begin
         int n = 0;
         do begin tick(); n++; end while (!imem_ready && n < 10);
         if (!imem_ready) begin checks++; failures++; $display("FAIL wait_accept2 timeout"); end
      end
      lat = 0;
      tick();
      #2 reset = 1'b1; ready_en = 1'b0;
      tick();
      #2 reset = 1'b0;
      tick(); tick();
      chk("rmid_valid", {31'h0, ValidF}, 32'h0); chk("rmid_req", {31'h0, imem_req}, 32'h1);
      chk("rmid_addr", imem_addr, 32'h0); chk("rmid_instr", InstrF, 32'h0000_0013);
      ready_en = 1'b1;
      wait_valid("rmid_fetch");
      chk("rmid_pcf", PCF, 32'h0); chk("rmid_fetch_instr", InstrF, 32'hC0DE_0000);

`ifdef IF_FETCH_PERF_EN
      tick();
      #2 reset = 1'b1;
      tick();
      #2 reset = 1'b0;
      chk("perf_rst_f", fetch_count, 32'h0); chk("perf_rst_r", redirect_count, 32'h0);
      wait_valid("perf0"); wait_valid("perf1"); wait_valid("perf2");
      tick();
      PCSrcE = 1'b1; PCTargetE = 32'h40;
      tick();
      PCSrcE = 1'b0;
      tick();
      chk("perf_f", fetch_count, 32'h3); chk("perf_r", redirect_count, 32'h1);
`endif

      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
